// File: rtl/wb_burst_ram.sv
// Wishbone B3 word-addressed RAM with registered ack and CTI/BTE burst support.
// Optional `WB_BURST_RAM_BOUNDS_ERR_EN: out-of-range beats answer with wb_err_o instead of aliasing.
module wb_burst_ram #(
  parameter int    AW      = 32,
  parameter int    DEPTH   = 1024,
  parameter string MEMFILE = ""
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o
);

  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SINGLE = 2'd1;
  localparam logic [1:0] ST_BURST  = 2'd2;

  localparam logic [2:0] CTI_INCR = 3'b010;

  logic [31:0]   mem_q [DEPTH];
  logic [1:0]    state_q, state_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [31:0]   dat_q, dat_d;
  logic [IW-1:0] baddr_q, baddr_d;

  logic [IW-1:0] req_idx;
  logic [IW-1:0] wrap_mask;
  logic [IW-1:0] nxt_idx;
  logic          wr_en;
  logic [31:0]   wr_merged;
  logic [31:0]   nxt_dat;
  logic          req_oob;
  logic          nxt_oob;

  assign req_idx = wb_adr_i[IW+1:2];

  always_comb begin
    case (wb_bte_i)
      2'b01:   wrap_mask = IW'(3);
      2'b10:   wrap_mask = IW'(7);
      2'b11:   wrap_mask = IW'(15);
      default: wrap_mask = '1;
    endcase
  end

  // Wrapping bursts only advance the low bits; a linear burst uses an all-ones mask.
  assign nxt_idx = (baddr_q & ~wrap_mask) | ((baddr_q + IW'(1)) & wrap_mask);

  assign wr_en = ack_q & wb_cyc_i & wb_stb_i & wb_we_i;

  always_comb begin
    wr_merged = mem_q[baddr_q];
    for (int b = 0; b < 4; b++) begin
      if (wb_sel_i[b]) wr_merged[8*b +: 8] = wb_dat_i[8*b +: 8];
    end
  end

  // Prefetch sees a same-cycle write to the same word (write-first).
  assign nxt_dat = (wr_en && (nxt_idx == baddr_q)) ? wr_merged : mem_q[nxt_idx];

`ifdef WB_BURST_RAM_BOUNDS_ERR_EN
  logic unused_adr;
  assign unused_adr = ^wb_adr_i[1:0];
  assign req_oob    = |wb_adr_i[AW-1:IW+2];
  assign nxt_oob    = (wb_bte_i == 2'b00) && (&baddr_q);
`else
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[AW-1:IW+2], wb_adr_i[1:0]};
  assign req_oob    = 1'b0;
  assign nxt_oob    = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    err_d   = err_q;
    dat_d   = dat_q;
    baddr_d = baddr_q;
    if (!wb_cyc_i) begin
      state_d = ST_IDLE;
      ack_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_d = 1'b0;
          err_d = 1'b0;
          if (wb_stb_i) begin
            baddr_d = req_idx;
            if (req_oob) begin
              err_d   = 1'b1;
              dat_d   = '0;
              state_d = ST_SINGLE;
            end else begin
              ack_d   = 1'b1;
              dat_d   = mem_q[req_idx];
              state_d = (wb_cti_i == CTI_INCR) ? ST_BURST : ST_SINGLE;
            end
          end
        end
        ST_BURST: begin
          if (!wb_stb_i || (wb_cti_i != CTI_INCR)) begin
            ack_d   = 1'b0;
            state_d = ST_IDLE;
          end else if (nxt_oob) begin
            ack_d   = 1'b0;
            err_d   = 1'b1;
            dat_d   = '0;
            baddr_d = nxt_idx;
            state_d = ST_SINGLE;
          end else begin
            baddr_d = nxt_idx;
            dat_d   = nxt_dat;
          end
        end
        default: begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      baddr_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      baddr_q <= baddr_d;
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM; contents survive wb_rst_i.
  always_ff @(posedge wb_clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem_q[baddr_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;

endmodule
